// File: rtl/core_run_pkg.sv
// Shared types and constants for the core run controller.
package core_run_pkg;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_DONE
    } run_state_t;

    // Outcome of a single RUN edge; anything but RES_NONE ends the run.
    typedef enum logic [2:0] {
        RES_NONE,
        RES_PASS,
        RES_FAIL,
        RES_HALT,
        RES_TIMEOUT
    } run_result_t;

    // Conventional tohost mailbox address used by the test programs.
    localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;

endpackage

// File: rtl/core_run_halt_det.sv
// PC self-loop detector: flags when HALT_REPEAT consecutive valid PC samples
// are identical. Invalid cycles are transparent to the streak.
module core_run_halt_det #(
    parameter int ADDR_W      = 32,
    parameter int HALT_REPEAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    input  logic              pc_valid,
    input  logic [ADDR_W-1:0] pc,
    output logic              hit
);

    // Streak of 0 means no valid PC has been seen since the last clear.
    localparam int SW = (HALT_REPEAT < 1) ? 1 : $clog2(HALT_REPEAT + 1);
    localparam logic [SW-1:0] REP = SW'(HALT_REPEAT);

    logic [ADDR_W-1:0] last_pc_q;
    logic [SW-1:0]     streak_q;
    logic [SW-1:0]     streak_d;
    logic              sample;

    // Next streak length; saturates at HALT_REPEAT so it cannot wrap.
    always_comb begin
        sample   = en && pc_valid;
        streak_d = streak_q;
        if (sample) begin
            if ((streak_q != '0) && (pc == last_pc_q)) begin
                streak_d = (streak_q == REP) ? streak_q : streak_q + 1'b1;
            end else begin
                streak_d = {{(SW-1){1'b0}}, 1'b1};
            end
        end
        hit = (HALT_REPEAT != 0) && sample && (streak_d == REP);
    end

    // Track the last valid PC and the current streak length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pc_q <= '0;
            streak_q  <= '0;
        end else if (clear) begin
            last_pc_q <= '0;
            streak_q  <= '0;
        end else if (sample) begin
            last_pc_q <= pc;
            streak_q  <= streak_d;
        end
    end

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller: sequences core reset, counts run cycles and latches the
// end-of-test cause (tohost store, PC self-loop or cycle budget).
module core_run_ctrl
    import core_run_pkg::*;
#(
    parameter int                RESET_CYCLES = 2,
    parameter int                MAX_CYCLES   = 150,
    parameter int                CNT_W        = 32,
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR  = ADDR_W'(TOHOST_ADDR_DEFAULT),
    parameter int                HALT_REPEAT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              core_rst,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              pc_valid,
    input  logic [ADDR_W-1:0] pc,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              halted,
    output logic              timeout,
    output logic [30:0]       exit_code,
    output logic [CNT_W-1:0]  cycle_count
);

    if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
        $error("core_run_ctrl: RESET_CYCLES must be >= 1");
    end
    if (MAX_CYCLES < 1) begin : g_bad_max_cycles
        $error("core_run_ctrl: MAX_CYCLES must be >= 1");
    end
    if ((CNT_W < 63) && (longint'(MAX_CYCLES) >= (longint'(1) << CNT_W))) begin : g_cnt_too_narrow
        $error("core_run_ctrl: MAX_CYCLES does not fit in CNT_W");
    end

    localparam int               RW      = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES);
    localparam logic [RW-1:0]    RC_LAST = RW'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_CYCLES);

    run_state_t        state_q;
    logic [RW-1:0]     rcnt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              core_rst_q;
    logic              done_q, pass_q, fail_q, halted_q, timeout_q;
    logic [30:0]       exit_q;

    logic              restart;
    logic              halt_hit;
    logic              tohost_hit;
    logic [CNT_W-1:0]  cnt_inc;
    run_result_t       result;

    core_run_halt_det #(
        .ADDR_W      (ADDR_W),
        .HALT_REPEAT (HALT_REPEAT)
    ) u_halt_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (restart),
        .en       (state_q == ST_RUN),
        .pc_valid (pc_valid),
        .pc       (pc),
        .hit      (halt_hit)
    );

    // Resolve this edge's termination cause: tohost beats halt beats timeout.
    always_comb begin
        restart    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        cnt_inc    = cnt_q + 1'b1;
        tohost_hit = mem_we && (mem_addr == TOHOST_ADDR) && (mem_wdata != 32'd0);
        result     = RES_NONE;
        if (tohost_hit) begin
            result = (mem_wdata == 32'd1) ? RES_PASS : RES_FAIL;
        end else if (halt_hit) begin
            result = RES_HALT;
        end else if (cnt_inc == MAX_C) begin
            result = RES_TIMEOUT;
        end
    end

    // Sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rcnt_q     <= '0;
            cnt_q      <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
            exit_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (restart) begin
                        state_q    <= ST_RESET;
                        rcnt_q     <= '0;
                        cnt_q      <= '0;
                        core_rst_q <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        fail_q     <= 1'b0;
                        halted_q   <= 1'b0;
                        timeout_q  <= 1'b0;
                        exit_q     <= '0;
                    end
                end
                ST_RESET: begin
                    if (rcnt_q == RC_LAST) begin
                        state_q    <= ST_RUN;
                        core_rst_q <= 1'b0;
                    end else begin
                        rcnt_q <= rcnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    // The terminating edge is still counted as a run cycle.
                    cnt_q <= cnt_inc;
                    if (result != RES_NONE) begin
                        state_q    <= ST_DONE;
                        core_rst_q <= 1'b1;
                        done_q     <= 1'b1;
                        pass_q     <= (result == RES_PASS);
                        fail_q     <= (result == RES_FAIL);
                        halted_q   <= (result == RES_HALT);
                        timeout_q  <= (result == RES_TIMEOUT);
                        exit_q     <= (result == RES_FAIL) ? mem_wdata[31:1] : '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign core_rst    = core_rst_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign halted      = halted_q;
    assign timeout     = timeout_q;
    assign exit_code   = exit_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl. Inputs change and outputs are sampled on
// the falling edge; the design acts on the rising edge.
module tb_core_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        pc_valid = 1'b0;
    logic [31:0] pc = '0;
    logic        core_rst, done, pass, fail, halted, timeout;
    logic [30:0] exit_code;
    logic [31:0] cycle_count;

    int errs = 0;
    int checks = 0;

    core_run_ctrl #(
        .RESET_CYCLES (2),
        .MAX_CYCLES   (150),
        .CNT_W        (32),
        .ADDR_W       (32),
        .TOHOST_ADDR  (32'h0000_1000),
        .HALT_REPEAT  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .core_rst    (core_rst),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .pc_valid    (pc_valid),
        .pc          (pc),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .halted      (halted),
        .timeout     (timeout),
        .exit_code   (exit_code),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge passes; returns on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Store presented for exactly one rising edge.
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_we = 1'b1; mem_addr = a; mem_wdata = d;
        step(1);
        mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    endtask

    // Pulse start and confirm status clears and core_rst is high for two cycles.
    task automatic boot(input string tag);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check({tag, ".rst1"}, core_rst, 1);
        check({tag, ".clr"}, {done, pass, fail, halted, timeout}, 0);
        check({tag, ".cnt0"}, cycle_count, 0);
        check({tag, ".exit0"}, exit_code, 0);
        step(1);
        check({tag, ".rst2"}, core_rst, 1);
        step(1);
        check({tag, ".run"}, core_rst, 0);
        check({tag, ".runcnt"}, cycle_count, 0);
    endtask

    logic [31:0] pcseq [6] = '{32'h40, 32'h40, 32'h44, 32'h40, 32'h40, 32'h40};

    initial begin
        // Reset state
        step(3);
        check("rst.core_rst", core_rst, 1);
        check("rst.done", done, 0);
        check("rst.cnt", cycle_count, 0);
        check("rst.status", {pass, fail, halted, timeout}, 0);
        rst_n = 1'b1;
        step(2);
        check("idle.core_rst", core_rst, 1);

        // Pass on RUN edge 10, with ignored stores on edges 3 and 5
        boot("pass");
        step(2);
        store(32'h1004, 32'd1);
        step(1);
        store(32'h1000, 32'd0);
        step(4);
        check("pass.early_done", done, 0);
        check("pass.early_cnt", cycle_count, 9);
        store(32'h1000, 32'd1);
        check("pass.done", done, 1);
        check("pass.pass", pass, 1);
        check("pass.others", {fail, halted, timeout}, 0);
        check("pass.cnt", cycle_count, 10);
        check("pass.core_rst", core_rst, 1);
        step(3);
        check("pass.hold_cnt", cycle_count, 10);
        check("pass.hold_done", {done, pass, core_rst}, 3'b111);

        // Fail with exit code
        boot("fail");
        step(3);
        store(32'h1000, 32'h0000_000B);
        check("fail.fail", fail, 1);
        check("fail.exit", exit_code, 5);
        check("fail.pass", pass, 0);
        check("fail.cnt", cycle_count, 4);
        check("fail.done", done, 1);

        // Halt: four samples of 0x40 with one invalid gap
        boot("halt");
        pc_valid = 1'b1; pc = 32'h40;
        step(2);
        pc_valid = 1'b0;
        step(1);
        pc_valid = 1'b1;
        step(1);
        check("halt.not_yet", done, 0);
        step(1);
        pc_valid = 1'b0;
        check("halt.halted", halted, 1);
        check("halt.done", done, 1);
        check("halt.cnt", cycle_count, 5);
        check("halt.others", {pass, fail, timeout}, 0);

        // Broken streak, then timeout
        boot("tmo");
        for (int i = 0; i < 6; i++) begin
            pc_valid = 1'b1; pc = pcseq[i];
            step(1);
        end
        pc_valid = 1'b0;
        check("tmo.nohalt", done, 0);
        check("tmo.cnt6", cycle_count, 6);
        step(143);
        check("tmo.before", done, 0);
        check("tmo.cnt149", cycle_count, 149);
        step(1);
        check("tmo.timeout", timeout, 1);
        check("tmo.cnt", cycle_count, 150);
        check("tmo.others", {pass, fail, halted}, 0);

        // Priority on edge 150: tohost over halt and timeout
        boot("prio1");
        step(146);
        pc_valid = 1'b1; pc = 32'h80;
        step(3);
        store(32'h1000, 32'd1);
        pc_valid = 1'b0;
        check("prio1.pass", pass, 1);
        check("prio1.others", {fail, halted, timeout}, 0);
        check("prio1.cnt", cycle_count, 150);

        // Priority on edge 150: halt over timeout
        boot("prio2");
        step(146);
        pc_valid = 1'b1; pc = 32'h80;
        step(4);
        pc_valid = 1'b0;
        check("prio2.halted", halted, 1);
        check("prio2.timeout", timeout, 0);
        check("prio2.cnt", cycle_count, 150);

        // Asynchronous reset in the middle of a run
        boot("mid");
        step(20);
        check("mid.cnt20", cycle_count, 20);
        #2 rst_n = 1'b0;
        #1;
        check("mid.core_rst", core_rst, 1);
        check("mid.cnt", cycle_count, 0);
        check("mid.status", {done, pass, fail, halted, timeout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        boot("again");
        step(1);
        store(32'h1000, 32'd1);
        check("again.pass", pass, 1);
        check("again.cnt", cycle_count, 2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
